// File: rtl/id_stall_ctrl_if.sv
// Handshake bundle between the pipeline hazard-detection signals and the ID-stage interlock.
// The master side is the pipeline; the slave side is the stall controller.
interface id_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             ID_uses_rs;
  logic             ID_uses_rt;
  logic             ID_is_branch;
  logic [4:0]       ID_EX_Write_register;
  logic             ID_EX_RegWrite;
  logic             ID_EX_MemRead;
  logic [4:0]       EX_MEM_Write_register;
  logic             EX_MEM_MemRead;
  logic             EX_MEM_MemWrite;
  logic             mem_ready;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Flush;
  logic             freeze;
  logic [CNT_W-1:0] stall_count;
  logic             mem_timeout;

  modport master (
    output IF_ID_rs, IF_ID_rt, ID_uses_rs, ID_uses_rt, ID_is_branch,
           ID_EX_Write_register, ID_EX_RegWrite, ID_EX_MemRead,
           EX_MEM_Write_register, EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready,
    input  PC_Write, IF_ID_Write, ID_EX_Flush, freeze, stall_count, mem_timeout
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, ID_uses_rs, ID_uses_rt, ID_is_branch,
           ID_EX_Write_register, ID_EX_RegWrite, ID_EX_MemRead,
           EX_MEM_Write_register, EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready,
    output PC_Write, IF_ID_Write, ID_EX_Flush, freeze, stall_count, mem_timeout
  );
endinterface

// File: rtl/id_stall_ctrl.sv
// ID-stage interlock: stalls fetch/decode for hazards forwarding cannot cover and
// freezes the back end while data memory is busy.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_RUN     | normal issue; hazard cost evaluated every cycle
//   S_STALL   | extra bubble cycles pending (rem_q), hazard not re-evaluated
//   S_MEMWAIT | data memory busy; pipeline frozen, pending bubbles in saved_q
module id_stall_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset_n,
  id_stall_ctrl_if.slave bus
);
  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_STALL   = 2'd1,
    S_MEMWAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [1:0]       saved_q, saved_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       match_ex, match_mem, mem_wait, stalled, frozen;
  logic [1:0] cost;
  logic       pc_write, if_id_write, id_ex_flush, freeze_o;

  always_comb begin
    match_ex  = (bus.ID_EX_Write_register != 5'd0) &&
                ((bus.ID_uses_rs && (bus.ID_EX_Write_register == bus.IF_ID_rs)) ||
                 (bus.ID_uses_rt && (bus.ID_EX_Write_register == bus.IF_ID_rt)));
    match_mem = (bus.EX_MEM_Write_register != 5'd0) &&
                ((bus.ID_uses_rs && (bus.EX_MEM_Write_register == bus.IF_ID_rs)) ||
                 (bus.ID_uses_rt && (bus.EX_MEM_Write_register == bus.IF_ID_rt)));
    mem_wait  = (bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite) & ~bus.mem_ready;
  end

  // Priority order matters: a branch behind a load in EX needs two bubbles.
  always_comb begin
    cost = 2'd0;
    if (bus.ID_is_branch && bus.ID_EX_MemRead && match_ex)
      cost = 2'd2;
    else if (bus.ID_is_branch && bus.ID_EX_RegWrite && match_ex)
      cost = 2'd1;
    else if (bus.ID_is_branch && bus.EX_MEM_MemRead && match_mem)
      cost = 2'd1;
    else if (bus.ID_EX_MemRead && match_ex)
      cost = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    saved_d = saved_q;
    timer_d = '0;
    case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d = S_MEMWAIT;
          saved_d = 2'd0;
        end else if (cost == 2'd2) begin
          state_d = S_STALL;
          rem_d   = 2'd1;
        end
      end
      S_STALL: begin
        if (mem_wait) begin
          state_d = S_MEMWAIT;
          saved_d = rem_q;
        end else if (rem_q <= 2'd1) begin
          state_d = S_RUN;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end
      S_MEMWAIT: begin
        if (bus.mem_ready) begin
          if (saved_q != 2'd0) begin
            state_d = S_STALL;
            rem_d   = saved_q;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          timer_d = (timer_q == TMR_MAX) ? TMR_MAX : timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    frozen      = mem_wait || (state_q == S_MEMWAIT);
    stalled     = (state_q == S_STALL) || ((state_q == S_RUN) && (cost != 2'd0));
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_flush = 1'b0;
    freeze_o    = 1'b0;
    if (!reset_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (frozen) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      freeze_o    = 1'b1;
    end else if (stalled) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    timeout_d = timeout_q | (timer_d == TMR_MAX);
    cnt_d     = (!pc_write && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RUN;
      rem_q     <= 2'd0;
      saved_q   <= 2'd0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      saved_q   <= saved_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PC_Write    = pc_write;
  assign bus.IF_ID_Write = if_id_write;
  assign bus.ID_EX_Flush = id_ex_flush;
  assign bus.freeze      = freeze_o;
  assign bus.stall_count = cnt_q;
  assign bus.mem_timeout = timeout_q;
endmodule

// File: tb/tb_id_stall_ctrl.sv
// Testbench for id_stall_ctrl: directed pipeline scenarios plus randomized traffic
// checked against a cycle-level reference model of the interlock rules.
module tb_id_stall_ctrl;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   id_stall_ctrl_if #(.CNT_W(32)) bus ();
   id_stall_ctrl #(.CNT_W(32), .MEM_TIMEOUT(255)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       br;
      logic [4:0] exw;
      logic       exrw;
      logic       exmr;
      logic [4:0] memw;
      logic       memmr;
      logic       memmw;
      logic       rdy;
   } stim_t;

   // ctl vectors are {PC_Write, IF_ID_Write, ID_EX_Flush, freeze}
   localparam logic [3:0] C_PASS = 4'b1100;
   localparam logic [3:0] C_BUB  = 4'b0010;
   localparam logic [3:0] C_FRZ  = 4'b0001;

   int       m_extra, m_saved, m_wait_cycles;
   bit       m_in_wait, m_tmo;
   longint   m_stalls;
   logic [3:0] exp_ctl;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rdy = 1'b1;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      bus.IF_ID_rs              = s.rs;
      bus.IF_ID_rt              = s.rt;
      bus.ID_uses_rs            = s.urs;
      bus.ID_uses_rt            = s.urt;
      bus.ID_is_branch          = s.br;
      bus.ID_EX_Write_register  = s.exw;
      bus.ID_EX_RegWrite        = s.exrw;
      bus.ID_EX_MemRead         = s.exmr;
      bus.EX_MEM_Write_register = s.memw;
      bus.EX_MEM_MemRead        = s.memmr;
      bus.EX_MEM_MemWrite       = s.memmw;
      bus.mem_ready             = s.rdy;
   endtask

   function automatic logic [3:0] actual_ctl();
      return {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Flush, bus.freeze};
   endfunction

   function automatic bit reads(input logic [4:0] r);
      return (r != 5'd0) && ((bus.ID_uses_rs && r == bus.IF_ID_rs) ||
                             (bus.ID_uses_rt && r == bus.IF_ID_rt));
   endfunction

   function automatic int bubbles_needed();
      bit ex_hit  = reads(bus.ID_EX_Write_register);
      bit mem_hit = reads(bus.EX_MEM_Write_register);
      if (bus.ID_is_branch) begin
         if (bus.ID_EX_MemRead && ex_hit)   return 2;
         if (bus.ID_EX_RegWrite && ex_hit)  return 1;
         if (bus.EX_MEM_MemRead && mem_hit) return 1;
      end
      if (bus.ID_EX_MemRead && ex_hit) return 1;
      return 0;
   endfunction

   function automatic bit mem_busy();
      return (bus.EX_MEM_MemRead || bus.EX_MEM_MemWrite) && !bus.mem_ready;
   endfunction

   task automatic mdl_reset();
      m_extra = 0; m_saved = 0; m_wait_cycles = 0;
      m_in_wait = 0; m_tmo = 0; m_stalls = 0;
   endtask

   task automatic mdl_eval();
      if (m_in_wait || mem_busy())                   exp_ctl = C_FRZ;
      else if (m_extra > 0 || bubbles_needed() > 0)  exp_ctl = C_BUB;
      else                                           exp_ctl = C_PASS;
   endtask

   task automatic mdl_advance();
      int n;
      n = bubbles_needed();
      if (!exp_ctl[3] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (m_in_wait) begin
         if (bus.mem_ready) begin
            m_in_wait = 0;
            m_extra = m_saved;
            m_wait_cycles = 0;
         end else begin
            m_wait_cycles++;
            if (m_wait_cycles >= 255) m_tmo = 1;
         end
      end else if (mem_busy()) begin
         m_in_wait = 1;
         m_saved = m_extra;
         m_extra = 0;
      end else if (m_extra > 0) begin
         m_extra--;
      end else if (n > 0) begin
         m_extra = n - 1;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      apply(idle());
      #3;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      apply(idle());
      #2;
      checks++;
      if (actual_ctl() !== C_BUB) begin
         errors++;
         $display("FAIL reset_ctl: got %b expected %b", actual_ctl(), C_BUB);
      end
      checks++;
      if (bus.stall_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", bus.stall_count);
      end
      checks++;
      if (bus.mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout: got %b expected 0", bus.mem_timeout);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (actual_ctl() !== C_PASS) begin
         errors++;
         $display("FAIL reset_release_ctl: got %b expected %b", actual_ctl(), C_PASS);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_use();
      stim_t st[2];
      logic [3:0] ex[2];
      do_reset();
      st[0] = idle(); st[0].rs = 5'd8; st[0].urs = 1; st[0].exw = 5'd8; st[0].exrw = 1; st[0].exmr = 1;
      st[1] = idle(); st[1].rs = 5'd8; st[1].urs = 1; st[1].memw = 5'd8; st[1].memmr = 1;
      ex[0] = C_BUB; ex[1] = C_PASS;
      for (int i = 0; i < 2; i++) begin
         apply(st[i]);
         #1;
         checks++;
         if (actual_ctl() !== ex[i]) begin
            errors++;
            $display("FAIL load_use step%0d: got %b expected %b", i, actual_ctl(), ex[i]);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.stall_count !== 32'd1) begin
         errors++;
         $display("FAIL load_use_count: got %0d expected 1", bus.stall_count);
      end
   endtask

   task automatic test_branch_load();
      stim_t st[3];
      logic [3:0] ex[3];
      do_reset();
      st[0] = idle(); st[0].br = 1; st[0].rs = 5'd9; st[0].urs = 1; st[0].exw = 5'd9; st[0].exrw = 1; st[0].exmr = 1;
      st[1] = idle(); st[1].br = 1; st[1].rs = 5'd9; st[1].urs = 1; st[1].memw = 5'd9; st[1].memmr = 1;
      st[2] = idle(); st[2].br = 1; st[2].rs = 5'd9; st[2].urs = 1;
      ex[0] = C_BUB; ex[1] = C_BUB; ex[2] = C_PASS;
      for (int i = 0; i < 3; i++) begin
         apply(st[i]);
         #1;
         checks++;
         if (actual_ctl() !== ex[i]) begin
            errors++;
            $display("FAIL branch_load step%0d: got %b expected %b", i, actual_ctl(), ex[i]);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.stall_count !== 32'd2) begin
         errors++;
         $display("FAIL branch_load_count: got %0d expected 2", bus.stall_count);
      end
   endtask

   task automatic test_branch_alu();
      stim_t st[3];
      logic [3:0] ex[3];
      do_reset();
      st[0] = idle(); st[0].br = 1; st[0].rs = 5'd10; st[0].urs = 1; st[0].exw = 5'd10; st[0].exrw = 1;
      st[1] = idle(); st[1].br = 1; st[1].rs = 5'd10; st[1].urs = 1; st[1].memw = 5'd10;
      st[2] = idle(); st[2].br = 1; st[2].rs = 5'd0; st[2].urs = 1; st[2].exw = 5'd0; st[2].exrw = 1; st[2].exmr = 1;
      ex[0] = C_BUB; ex[1] = C_PASS; ex[2] = C_PASS;
      for (int i = 0; i < 3; i++) begin
         apply(st[i]);
         #1;
         checks++;
         if (actual_ctl() !== ex[i]) begin
            errors++;
            $display("FAIL branch_alu step%0d: got %b expected %b", i, actual_ctl(), ex[i]);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.stall_count !== 32'd1) begin
         errors++;
         $display("FAIL branch_alu_count: got %0d expected 1", bus.stall_count);
      end
   endtask

   task automatic test_memwait_in_stall();
      stim_t st[7];
      logic [3:0] ex[7];
      do_reset();
      st[0] = idle(); st[0].br = 1; st[0].rs = 5'd9; st[0].urs = 1; st[0].exw = 5'd9; st[0].exrw = 1; st[0].exmr = 1;
      for (int i = 1; i < 5; i++) begin
         st[i] = idle(); st[i].br = 1; st[i].rs = 5'd9; st[i].urs = 1;
         st[i].memw = 5'd9; st[i].memmr = 1; st[i].rdy = (i == 4);
      end
      st[5] = idle(); st[5].br = 1; st[5].rs = 5'd9; st[5].urs = 1;
      st[6] = st[5];
      ex[0] = C_BUB; ex[1] = C_FRZ; ex[2] = C_FRZ; ex[3] = C_FRZ; ex[4] = C_FRZ;
      ex[5] = C_BUB; ex[6] = C_PASS;
      for (int i = 0; i < 7; i++) begin
         apply(st[i]);
         #1;
         checks++;
         if (actual_ctl() !== ex[i]) begin
            errors++;
            $display("FAIL memwait_stall step%0d: got %b expected %b", i, actual_ctl(), ex[i]);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.stall_count !== 32'd6) begin
         errors++;
         $display("FAIL memwait_stall_count: got %0d expected 6", bus.stall_count);
      end
   endtask

   task automatic test_mem_timeout();
      stim_t s;
      do_reset();
      s = idle(); s.memmr = 1; s.memw = 5'd4; s.rdy = 0;
      apply(s);
      for (int k = 0; k <= 256; k++) begin
         #1;
         checks++;
         if (actual_ctl() !== C_FRZ || bus.mem_timeout !== (k >= 256)) begin
            errors++;
            $display("FAIL timeout_wait k=%0d: ctl=%b tmo=%b expected ctl=%b tmo=%b",
                     k, actual_ctl(), bus.mem_timeout, C_FRZ, (k >= 256));
         end
         @(posedge clk);
         #1;
      end
      s.rdy = 1;
      apply(s);
      #1;
      checks++;
      if (actual_ctl() !== C_FRZ || bus.mem_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_ready: ctl=%b tmo=%b expected ctl=%b tmo=1", actual_ctl(), bus.mem_timeout, C_FRZ);
      end
      @(posedge clk);
      #1;
      apply(idle());
      #1;
      checks++;
      if (actual_ctl() !== C_PASS || bus.mem_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: ctl=%b tmo=%b expected ctl=%b tmo=1", actual_ctl(), bus.mem_timeout, C_PASS);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_in_stall();
      stim_t s;
      do_reset();
      s = idle(); s.br = 1; s.rs = 5'd9; s.urs = 1; s.exw = 5'd9; s.exrw = 1; s.exmr = 1;
      apply(s);
      @(posedge clk);
      #1;
      s = idle(); s.br = 1; s.rs = 5'd9; s.urs = 1; s.memw = 5'd9; s.memmr = 1;
      apply(s);
      #1;
      checks++;
      if (actual_ctl() !== C_BUB || bus.stall_count !== 32'd1) begin
         errors++;
         $display("FAIL rst_stall_pre: ctl=%b cnt=%0d expected ctl=%b cnt=1", actual_ctl(), bus.stall_count, C_BUB);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (actual_ctl() !== C_BUB || bus.stall_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_stall_async: ctl=%b cnt=%0d expected ctl=%b cnt=0", actual_ctl(), bus.stall_count, C_BUB);
      end
      @(negedge clk);
      reset_n = 1'b1;
      s = idle(); s.br = 1; s.rs = 5'd9; s.urs = 1;
      apply(s);
      #1;
      checks++;
      if (actual_ctl() !== C_PASS || bus.stall_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_stall_release: ctl=%b cnt=%0d expected ctl=%b cnt=0", actual_ctl(), bus.stall_count, C_PASS);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      stim_t s;
      do_reset();
      mdl_reset();
      for (int n = 0; n < 3000; n++) begin
         s.rs    = 5'($urandom_range(0, 3));
         s.rt    = 5'($urandom_range(0, 3));
         s.urs   = 1'($urandom_range(0, 1));
         s.urt   = 1'($urandom_range(0, 1));
         s.br    = ($urandom_range(0, 3) == 0);
         s.exw   = 5'($urandom_range(0, 3));
         s.exrw  = 1'($urandom_range(0, 1));
         s.exmr  = s.exrw & 1'($urandom_range(0, 1));
         s.memw  = 5'($urandom_range(0, 3));
         s.memmr = ($urandom_range(0, 3) == 0);
         s.memmw = !s.memmr && ($urandom_range(0, 5) == 0);
         s.rdy   = ($urandom_range(0, 3) != 0);
         apply(s);
         #1;
         mdl_eval();
         checks++;
         if (actual_ctl() !== exp_ctl) begin
            errors++;
            $display("FAIL random_ctl cycle %0d: got %b expected %b", n, actual_ctl(), exp_ctl);
         end
         checks++;
         if (bus.stall_count !== 32'(m_stalls)) begin
            errors++;
            $display("FAIL random_count cycle %0d: got %0d expected %0d", n, bus.stall_count, m_stalls);
         end
         checks++;
         if (bus.mem_timeout !== m_tmo) begin
            errors++;
            $display("FAIL random_timeout cycle %0d: got %b expected %b", n, bus.mem_timeout, m_tmo);
         end
         mdl_advance();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      apply(idle());
      test_reset();
      test_load_use();
      test_branch_load();
      test_branch_alu();
      test_memwait_in_stall();
      test_mem_timeout();
      test_reset_in_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
